// File: rtl/csa_mult_sequencer_if.sv
// rtl/csa_mult_sequencer_if.sv - operand/result handshake bundle for csa_mult_sequencer
interface csa_mult_sequencer_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/csa_mult_sequencer.sv
// rtl/csa_mult_sequencer.sv - sequential carry-save unsigned multiplier, one partial product per cycle
// Optional feature macro: CSA_MULT_EARLY_EXIT_EN (stop reducing once remaining multiplier bits are zero)
module csa_mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  csa_mult_sequencer_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, REDUCE, FINAL, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [PW-1:0]   sum;
  logic [PW-1:0]   carry;
  logic [PW-1:0]   pp;
  logic [PW-2:0]   maj;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   product_r;
  logic            out_valid_r;
  logic            reduce_last;
  logic            b_zero;

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == REDUCE) || (state == FINAL);
  assign bus.out_valid = out_valid_r;
  assign bus.product   = product_r;

  // The carry out of the top bit is dropped: arithmetic is mod 2^(2*WIDTH).
  always_comb begin
    pp  = b_reg[0] ? a_reg : '0;
    maj = (sum[PW-2:0] & carry[PW-2:0]) | (sum[PW-2:0] & pp[PW-2:0]) |
          (carry[PW-2:0] & pp[PW-2:0]);
  end

  always_comb begin
    b_zero = (bus.b == '0);
`ifdef CSA_MULT_EARLY_EXIT_EN
    reduce_last = (cnt == CNT_LAST) || (b_reg[WIDTH-1:1] == '0);
`else
    reduce_last = (cnt == CNT_LAST);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
`ifdef CSA_MULT_EARLY_EXIT_EN
          state_nxt = b_zero ? FINAL : REDUCE;
`else
          state_nxt = b_zero ? REDUCE : REDUCE;
`endif
        end
      end
      REDUCE:  if (reduce_last) state_nxt = FINAL;
      FINAL:   state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg       <= '0;
      b_reg       <= '0;
      sum         <= '0;
      carry       <= '0;
      cnt         <= '0;
      product_r   <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg <= {{WIDTH{1'b0}}, bus.a};
            b_reg <= bus.b;
            sum   <= '0;
            carry <= '0;
            cnt   <= '0;
          end
        end
        REDUCE: begin
          sum   <= sum ^ carry ^ pp;
          carry <= {maj, 1'b0};
          a_reg <= a_reg << 1;
          b_reg <= b_reg >> 1;
          cnt   <= cnt + 1'b1;
        end
        FINAL: begin
          product_r   <= sum + carry;
          out_valid_r <= 1'b1;
        end
        DONE: begin
          if (bus.out_ready) out_valid_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_csa_mult_sequencer.sv
// tb/tb_csa_mult_sequencer.sv - scoreboard bench for csa_mult_sequencer
module tb_csa_mult_sequencer;
  logic clk;
  logic reset;
  int   compared;
  int   mismatched;
  logic [63:0] exp_q[$];

  csa_mult_sequencer_if #(.WIDTH(32)) bus ();

  csa_mult_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_lat(input logic [31:0] bv);
`ifdef CSA_MULT_EARLY_EXIT_EN
    int m;
    if (bv == 32'd0) return 1;
    m = 0;
    for (int i = 0; i < 32; i++) if (bv[i]) m = i;
    return m + 2;
`else
    return (bv == 32'd0) ? 33 : 33;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents operands for one edge; caller guarantees in_ready is high.
  task automatic send(input logic [31:0] av, input logic [31:0] bv);
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    exp_q.push_back(64'(av) * 64'(bv));
    step();
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
  endtask

  task automatic wait_out(output int lat, output bit to);
    lat = 0;
    to  = 1'b0;
    while (!bus.out_valid) begin
      if (lat > 200) begin
        to = 1'b1;
        return;
      end
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    compared++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.product !== 64'd0) begin
      mismatched++;
      $display("FAIL reset_state: got rdy=%b vld=%b busy=%b prod=%h, need 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.product);
    end
  endtask

  task automatic run_one(input string name, input logic [31:0] av, input logic [31:0] bv);
    int lat;
    bit to;
    logic [63:0] e;
    send(av, bv);
    compared++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_busy: got busy=%b rdy=%b, need 1 0", name, bus.busy, bus.in_ready);
    end
    wait_out(lat, to);
    e = exp_q.pop_front();
    compared++;
    if (to) begin
      mismatched++;
      $display("FAIL %s_timeout: out_valid never rose", name);
      return;
    end
    if (bus.product !== e) begin
      mismatched++;
      $display("FAIL %s_product: got %h, need %h", name, bus.product, e);
    end
    compared++;
    if (lat !== exp_lat(bv)) begin
      mismatched++;
      $display("FAIL %s_latency: got %0d, need %0d", name, lat, exp_lat(bv));
    end
    step();
    compared++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_handshake: got vld=%b rdy=%b, need 0 1", name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_small();
    run_one("small", 32'd3, 32'd5);
  endtask

  task automatic test_max();
    run_one("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  task automatic test_zero();
    run_one("zero_a", 32'd0, 32'h8000_0000);
    run_one("zero_b", 32'h1234, 32'd0);
  endtask

  task automatic test_backpressure();
    int lat;
    bit to;
    logic [63:0] e;
    bus.out_ready = 1'b0;
    send(32'hDEAD_BEEF, 32'h0001_0203);
    wait_out(lat, to);
    e = exp_q.pop_front();
    compared++;
    if (to) begin
      mismatched++;
      $display("FAIL bp_timeout: out_valid never rose");
      bus.out_ready = 1'b1;
      return;
    end
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.a        = $urandom;
      bus.b        = $urandom;
      step();
      compared++;
      if (bus.out_valid !== 1'b1 || bus.product !== e || bus.in_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL bp_hold%0d: got vld=%b prod=%h rdy=%b, need 1 %h 0",
                 i, bus.out_valid, bus.product, bus.in_ready, e);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    compared++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_release: got vld=%b rdy=%b, need 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    send(32'd7, 32'd9);
    repeat (10) step();
    void'(exp_q.pop_front());
    reset = 1'b1;
    #1;
    compared++;
    if (bus.out_valid !== 1'b0 || bus.product !== 64'd0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_mid: got vld=%b prod=%h busy=%b rdy=%b, need 0 0 0 1",
               bus.out_valid, bus.product, bus.busy, bus.in_ready);
    end
    #1;
    reset = 1'b0;
    step();
    run_one("after_reset", 32'd6, 32'd7);
  endtask

  task automatic test_random();
    int lat;
    bit to;
    int stall;
    logic [31:0] av;
    logic [31:0] bv;
    logic [63:0] e;
    for (int n = 0; n < 1000; n++) begin
      av = $urandom;
      bv = (n % 8 == 0) ? ($urandom >> $urandom_range(0, 31)) : $urandom;
      stall = $urandom_range(0, 3);
      bus.out_ready = (stall == 0);
      send(av, bv);
      wait_out(lat, to);
      if (to) begin
        compared++;
        mismatched++;
        $display("FAIL rand_timeout: op %0d", n);
        bus.out_ready = 1'b1;
        return;
      end
      e = exp_q.pop_front();
      compared++;
      if (bus.product !== e || lat !== exp_lat(bv)) begin
        mismatched++;
        $display("FAIL rand_op%0d: got prod=%h lat=%0d, need %h %0d", n, bus.product, lat, e, exp_lat(bv));
      end
      repeat (stall) step();
      bus.out_ready = 1'b1;
      step();
      compared++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL rand_release%0d: got vld=%b rdy=%b, need 0 1", n, bus.out_valid, bus.in_ready);
      end
    end
    compared++;
    if (exp_q.size() !== 0) begin
      mismatched++;
      $display("FAIL rand_leftover: got %0d queued, need 0", exp_q.size());
    end
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    repeat (3) step();
    test_reset();
    reset = 1'b0;
    step();
    test_reset();
    test_small();
    test_max();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/csa_mult_sequencer.md
# csa_mult_sequencer

Sequential multiplier controller that time-shares one 2·WIDTH-bit carry-save adder stage and one 2·WIDTH-bit final carry-propagate adder to compute an unsigned WIDTH×WIDTH product. Partial products are scheduled into the CSA one per cycle, with sum and carry vectors held in registers between cycles. A single carry-propagate add then resolves the result. It sits between an operand source and a result consumer, using valid/ready handshakes on both sides. It is the area-reduced alternative to the fully parallel Wallace tree multiplier.

## Interface
- WIDTH, 32, operand width; product is 2·WIDTH bits
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operands a/b valid
- in_ready  output  1  block accepts operands (high only in IDLE)
- a  input  WIDTH  multiplicand (unsigned)
- b  input  WIDTH  multiplier (unsigned)
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  2·WIDTH  registered result
- busy  output  1  high in REDUCE or FINAL

## Operation
- States: IDLE, REDUCE, FINAL, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid: a_reg←{0,a}, b_reg←b, sum←0, carry←0, cnt←0, go to REDUCE.
- **REDUCE**, once per cycle:
  - pp = b_reg[0] ? a_reg : 0.
  - sum←sum^carry^pp.
  - carry←{maj(sum,carry,pp)[2·WIDTH-2:0],1'b0}. The bit shifted out of the top is discarded, because the arithmetic is mod 2^(2·WIDTH).
  - a_reg←a_reg<<1, b_reg←b_reg>>1, cnt←cnt+1.
  - When cnt==WIDTH-1, go to FINAL.
- **FINAL**: product←sum+carry (2·WIDTH-bit add, carry-out dropped); out_valid←1; go to DONE.
- **DONE**:
  - product and out_valid are held stable.
  - On out_ready: out_valid←0, go to IDLE.
  - in_ready stays 0 until IDLE is reached.
- in_valid outside IDLE is ignored; operands are not sampled.
- a and b are sampled only at the accept edge; later changes have no effect.
- Invariant at the end of REDUCE: sum+carry ≡ a·b mod 2^(2·WIDTH).

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, busy 0, product 0. All internal registers are 0.
- Asserting reset in any state aborts the operation immediately. No result is produced.
- Latency, counted from the accept edge to the edge that raises out_valid: WIDTH+1 cycles (33 at default), fixed when EARLY_EXIT_EN is undefined.
- Throughput: at most one operation per WIDTH+3 cycles. The minimum breakdown is DONE with out_ready=1 (1 cycle) plus IDLE accept (1 cycle).
- in_ready is combinational from state; out_valid and product are registered.
- out_ready is sampled only in DONE. If out_ready is already high when DONE is entered, the handshake completes on the first DONE cycle.

## Configuration
- Macro: CSA_MULT_EARLY_EXIT_EN.
- **Defined**:
  - REDUCE transitions to FINAL when the shifted multiplier (b_reg>>1) is zero, or when cnt==WIDTH-1, whichever comes first.
  - An accept with b==0 goes directly from IDLE to FINAL, with sum=carry=0.
  - Resulting latency: (msb index of b)+2 cycles, or 1 cycle when b==0.
- **Undefined**: REDUCE always runs exactly WIDTH cycles. Latency is the constant WIDTH+1.

## Test plan
- **Small operands**: a=3, b=5, out_ready=1.
  - product=0x000000000000000F.
  - out_valid rises 33 cycles after accept without the macro, 4 cycles with it.
- **Maximum operands**: a=b=0xFFFFFFFF → product=0xFFFFFFFE00000001, with correct carry handling across every cycle.
- **Backpressure**:
  - Hold out_ready=0 for 10 cycles after out_valid rises. Product and out_valid must stay stable, in_ready=0, and in_valid pulses are ignored.
  - Then raise out_ready: out_valid falls, and in_ready=1 on the next cycle.
- **Reset mid-operation**:
  - Start a=7, b=9, then assert reset at cycle 10 of REDUCE. Outputs must immediately read out_valid=0, product=0, busy=0, in_ready=1.
  - Then run a=6, b=7 → product=42.
- **Zero operands**:
  - a=0, b=0x80000000 → product=0, latency 33 in both configs.
  - a=0x1234, b=0 → product=0, latency 33 without the macro, 1 with it.
- **Random regression**: 1000 random a,b pairs with random out_ready stalls. Each product must equal a·b, with exactly one output per accepted input, delivered in order.
